// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: EMPTY/LOAD/RUN sequencer with a one-cycle registered fetch port.
// Define IMEM_PARITY_EN to store and check one even-parity bit per word.
module instr_mem_loadable #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 25,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              parity_err,
  output logic              busy
);

  // state   | meaning
  // S_EMPTY | after reset, no program accepted yet
  // S_LOAD  | program writes accepted, fetches blocked
  // S_RUN   | fetches served, writes ignored
  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, fault_q, par_err_q, load_err_q;
  logic [ADDR_W:0]   count_q, count_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_en, wr_bad, fetch_acc, enter_load, par_bad;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign wr_in_range = {1'b0, load_addr}  < DEPTH_L;
  assign rd_in_range = {1'b0, fetch_addr} < DEPTH_L;
  assign wr_idx      = load_addr[IDX_W-1:0];
  assign rd_idx      = fetch_addr[IDX_W-1:0];
  assign wr_en       = !rst && (state_q == S_LOAD) && load_we && wr_in_range;
  assign wr_bad      = (state_q == S_LOAD) && load_we && !wr_in_range;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign enter_load  = (state_q != S_LOAD) && (state_d == S_LOAD);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (load_en)   state_d = S_LOAD;
      S_LOAD:  if (load_done) state_d = S_RUN;
      S_RUN:   if (load_en)   state_d = S_LOAD;
      default:                state_d = S_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = (state_q != S_RUN);
    fetch_ready = (state_q == S_RUN) && !load_en;
  end

  // Storage is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_q[wr_idx] <= ^load_data;
  end

  assign par_bad = rd_in_range && ((^mem_q[rd_idx]) != par_q[rd_idx]);
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    instr_d = instr_q;
    if (fetch_acc) instr_d = rd_in_range ? mem_q[rd_idx] : NOP_WORD;
    count_d = count_q;
    if (enter_load)                  count_d = '0;
    else if (wr_en && count_q != '1) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      par_err_q  <= 1'b0;
      load_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      instr_q    <= instr_d;
      valid_q    <= fetch_acc;
      fault_q    <= fetch_acc && !rd_in_range;
      par_err_q  <= fetch_acc && par_bad;
      load_err_q <= wr_bad;
      count_q    <= count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign addr_fault  = fault_q;
  assign parity_err  = par_err_q;
  assign load_err    = load_err_q;
  assign load_count  = count_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable; fetch results checked through an expected-result queue.
module tb_instr_mem_loadable;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0, load_we = 1'b0, load_done = 1'b0;
  logic [7:0] load_addr = '0, load_data = '0;
  logic       load_err;
  logic [8:0] load_count;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = '0;
  logic       fetch_ready;
  logic [7:0] instr;
  logic       instr_valid, addr_fault, parity_err, busy;

  instr_mem_loadable dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_err(load_err), .load_count(load_count),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       p;
    int         c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instr", {24'd0, instr}, {24'd0, e.d});
          chk("addr_fault", {31'd0, addr_fault}, {31'd0, e.f});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.p});
          chk("latency_cycle", cyc, e.c);
        end
      end else begin
        chk("idle_flags", {30'd0, addr_fault, parity_err}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    step();
    load_we = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] d, input logic f, input logic p);
    exp_t e;
    fetch_req = 1'b1; fetch_addr = a;
    #1;
    chk("fetch_ready_run", {31'd0, fetch_ready}, 32'd1);
    e.d = d; e.f = f; e.p = p; e.c = cyc + 1;
    q.push_back(e);
    step();
    fetch_req = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    chk("rst_instr", {24'd0, instr}, 32'h00);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", {23'd0, load_count}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);

    // first program, last write together with load_done
    load_en = 1'b1; step(); load_en = 1'b0;
    chk("load_busy", {31'd0, busy}, 32'd1);
    wr(8'd0, 8'hA1);
    wr(8'd1, 8'hB2);
    load_done = 1'b1; wr(8'd2, 8'hC3); load_done = 1'b0;
    chk("load_count_3", {23'd0, load_count}, 32'd3);
    chk("run_busy", {31'd0, busy}, 32'd0);

    // back-to-back fetches, then instr must hold
    fetch(8'd0, 8'hA1, 1'b0, 1'b0);
    fetch(8'd1, 8'hB2, 1'b0, 1'b0);
    fetch(8'd2, 8'hC3, 1'b0, 1'b0);
    step(); step();
    chk("instr_hold", {24'd0, instr}, 32'hC3);

    // out-of-range fetches
    fetch(8'd25, 8'h00, 1'b1, 1'b0);
    fetch(8'd255, 8'h00, 1'b1, 1'b0);
    step();

    // fetch completes across RUN->LOAD; load_en beats a simultaneous fetch_req
    fetch(8'd1, 8'hB2, 1'b0, 1'b0);
    load_en = 1'b1; fetch_req = 1'b1; fetch_addr = 8'd2;
    #1;
    chk("load_en_wins", {31'd0, fetch_ready}, 32'd0);
    step();
    load_en = 1'b0; fetch_req = 1'b0;
    chk("reload_busy", {31'd0, busy}, 32'd1);
    chk("reload_count_clr", {23'd0, load_count}, 32'd0);

    // out-of-range write
    wr(8'd30, 8'h55);
    chk("load_err_pulse", {31'd0, load_err}, 32'd1);
    chk("load_err_count", {23'd0, load_count}, 32'd0);
    step();
    chk("load_err_clear", {31'd0, load_err}, 32'd0);

    // last legal address, then saturation of load_count
    wr(8'd24, 8'h5A);
    wr(8'd3, 8'h77);
    chk("load_count_2", {23'd0, load_count}, 32'd2);
    for (int i = 0; i < 520; i++) wr(8'd5, 8'h66);
    chk("load_count_sat", {23'd0, load_count}, 32'h1FF);
    load_done = 1'b1; step(); load_done = 1'b0;
    chk("run2_busy", {31'd0, busy}, 32'd0);
    fetch(8'd24, 8'h5A, 1'b0, 1'b0);
    fetch(8'd30, 8'h00, 1'b1, 1'b0);
    fetch(8'd3, 8'h77, 1'b0, 1'b0);

    // load_we ignored in RUN
    wr(8'd0, 8'hFF);
    chk("run_we_count", {23'd0, load_count}, 32'h1FF);
    fetch(8'd0, 8'hA1, 1'b0, 1'b0);
    step();

    // reset during a load keeps memory
    load_en = 1'b1; step(); load_en = 1'b0;
    wr(8'd1, 8'h11);
    wr(8'd2, 8'h22);
    chk("pre_rst_count", {23'd0, load_count}, 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_count", {23'd0, load_count}, 32'd0);
    chk("mid_rst_instr", {24'd0, instr}, 32'h00);
    chk("mid_rst_ready", {31'd0, fetch_ready}, 32'd0);
    load_en = 1'b1; step(); load_en = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    chk("run3_busy", {31'd0, busy}, 32'd0);
    fetch(8'd0, 8'hA1, 1'b0, 1'b0);
    fetch(8'd1, 8'h11, 1'b0, 1'b0);
    fetch(8'd2, 8'h22, 1'b0, 1'b0);

    // parity
`ifdef IMEM_PARITY_EN
    dut.par_q[1] = ~dut.par_q[1];
    fetch(8'd1, 8'h11, 1'b0, 1'b1);
    fetch(8'd0, 8'hA1, 1'b0, 1'b0);
    fetch(8'd26, 8'h00, 1'b1, 1'b0);
`else
    fetch(8'd1, 8'h11, 1'b0, 1'b0);
    fetch(8'd0, 8'hA1, 1'b0, 1'b0);
`endif

    step(); step(); step();
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
